// File: rtl/mul_seq_unit.sv
// Multi-cycle shift-add multiplier for MUL/MLA; one multiplier bit per clock.
// Define MUL_LONG_EN for a double-width product with the ResultHi output.
module mul_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
`ifdef MUL_LONG_EN
  output logic [WIDTH-1:0] ResultHi,
`endif
  output logic             N,
  output logic             Z
);

`ifdef MUL_LONG_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_nxt;
  logic [WIDTH-1:0] mplier;
  logic             last;
  logic             accept;

  assign last     = (count == CW'(WIDTH - 1));
  assign accept   = start && (state != RUN);
  assign prod_nxt = mplier[0] ? prod + mcand : prod;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result/flags capture the final adder output on the last RUN edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      Result   <= '0;
`ifdef MUL_LONG_EN
      ResultHi <= '0;
`endif
      N        <= 1'b0;
      Z        <= 1'b1;
    end else if (accept) begin
      count  <= '0;
      mcand  <= PW'(A);
      mplier <= B;
      prod   <= accumulate ? PW'(Acc) : '0;
    end else if (state == RUN) begin
      count  <= count + CW'(1);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      prod   <= prod_nxt;
      if (last) begin
        Result   <= prod_nxt[WIDTH-1:0];
`ifdef MUL_LONG_EN
        ResultHi <= prod_nxt[PW-1:WIDTH];
`endif
        N        <= prod_nxt[PW-1];
        Z        <= (prod_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Bench for mul_seq_unit: latency-level reference model plus directed
// and randomized operations.
module tb_mul_seq_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         accumulate = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Acc = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] Result;
  logic [W-1:0] hi_q;
  logic         N;
  logic         Z;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  mul_seq_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .accumulate(accumulate),
    .A(A),
    .B(B),
    .Acc(Acc),
    .busy(busy),
    .done(done),
    .Result(Result),
`ifdef MUL_LONG_EN
    .ResultHi(hi_q),
`endif
    .N(N),
    .Z(Z)
  );

`ifndef MUL_LONG_EN
  assign hi_q = '0;
`endif

  always #5 clk = ~clk;

  // Reference: an accepted op yields its full product WIDTH edges later
  logic           m_busy, m_done, m_n, m_z;
  int             m_cnt;
  logic [2*W-1:0] m_pend;
  logic [W-1:0]   m_res, m_hi;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_pend <= '0;
      m_res  <= '0;
      m_hi   <= '0;
      m_n    <= 1'b0;
      m_z    <= 1'b1;
    end else if (!m_busy && start) begin
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= W;
      m_pend <= ({{W{1'b0}}, A} * {{W{1'b0}}, B})
              + {{W{1'b0}}, (accumulate ? Acc : {W{1'b0}})};
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pend[W-1:0];
`ifdef MUL_LONG_EN
        m_hi   <= m_pend[2*W-1:W];
        m_n    <= m_pend[2*W-1];
        m_z    <= (m_pend == '0);
`else
        m_hi   <= '0;
        m_n    <= m_pend[W-1];
        m_z    <= (m_pend[W-1:0] == '0);
`endif
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("Result", 64'(Result), 64'(m_res));
      chk("ResultHi", 64'(hi_q), 64'(m_hi));
      chk("N", 64'(N), 64'(m_n));
      chk("Z", 64'(Z), 64'(m_z));
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] acc, input logic accm);
    A = a;
    B = b;
    Acc = acc;
    accumulate = accm;
  endtask

  // Waits for done; n = negedges since the accept edge (1 = right after it)
  task automatic wait_done(output int n, input bit noise);
    n = 1;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      if (!done && noise) begin
        start = ($urandom_range(0, 7) == 0);
        drive($urandom, $urandom, $urandom, 1'($urandom));
      end
    end
    if (!done) chk("done_timeout", 64'(n), 64'(W + 1));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] acc, input logic accm,
                        input logic [W-1:0] er, input logic en,
                        input logic ez);
    int n;
    @(negedge clk);
    start = 1'b1;
    drive(a, b, acc, accm);
    @(negedge clk);
    start = 1'b0;
    wait_done(n, 1'b0);
    chk("latency", 64'(n), 64'(W + 1));
    chk("lit_Result", 64'(Result), 64'(er));
    chk("lit_N", 64'(N), 64'(en));
    chk("lit_Z", 64'(Z), 64'(ez));
  endtask

  initial begin
    int n;
    int bc;
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_Result", 64'(Result), 64'd0);
    chk("rst_N", 64'(N), 64'd0);
    chk("rst_Z", 64'(Z), 64'd1);
    cmp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic MUL, with busy counted over the run
    @(negedge clk);
    start = 1'b1;
    drive(6, 7, 0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    bc = busy ? 1 : 0;
    n = 1;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end
    chk("mul_latency", 64'(n), 64'(W + 1));
    chk("mul_busy_cycles", 64'(bc), 64'(W));
    chk("mul_Result", 64'(Result), 64'd42);
    chk("mul_N", 64'(N), 64'd0);
    chk("mul_Z", 64'(Z), 64'd0);

    run_op(3, 5, 10, 1'b1, 32'd25, 1'b0, 1'b0);
`ifdef MUL_LONG_EN
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 32'h1, 1'b1, 1'b0);
    chk("long_hi", 64'(hi_q), 64'hFFFFFFFE);
`else
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 32'h1, 1'b0, 1'b0);
`endif
`ifdef MUL_LONG_EN
    run_op(32'h80000000, 2, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("long_hi2", 64'(hi_q), 64'h1);
`else
    run_op(32'h80000000, 2, 0, 1'b0, 32'h0, 1'b0, 1'b1);
`endif
`ifdef MUL_LONG_EN
    run_op(32'hFFFFFFFD, 4, 0, 1'b0, 32'hFFFFFFF4, 1'b0, 1'b0);
`else
    run_op(32'hFFFFFFFD, 4, 0, 1'b0, 32'hFFFFFFF4, 1'b1, 1'b0);
`endif

    // Start pulses during RUN must be ignored
    @(negedge clk);
    start = 1'b1;
    drive(7, 11, 0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    repeat (4) begin @(negedge clk); n++; end
    start = 1'b1;
    drive(1, 1, 5, 1'b1);
    @(negedge clk);
    n++;
    start = 1'b0;
    chk("run_hold_Result", 64'(Result), 64'hFFFFFFF4);
    repeat (14) begin @(negedge clk); n++; end
    start = 1'b1;
    drive(2, 2, 0, 1'b0);
    @(negedge clk);
    n++;
    start = 1'b0;
    while (!done && n < 80) begin @(negedge clk); n++; end
    chk("ign_latency", 64'(n), 64'(W + 1));
    chk("ign_Result", 64'(Result), 64'd77);
    repeat (3) @(negedge clk);
    chk("ign_no_redo", 64'(busy), 64'd0);

    // Back-to-back: start held high through DONE
    @(negedge clk);
    start = 1'b1;
    drive(5, 5, 0, 1'b0);
    @(negedge clk);
    drive(2, 9, 0, 1'b0);
    wait_done(n, 1'b0);
    chk("b2b_first", 64'(Result), 64'd25);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_done_pulse", 64'(done), 64'd0);
    wait_done(n, 1'b0);
    chk("b2b_latency", 64'(n), 64'(W + 1));
    chk("b2b_Result", 64'(Result), 64'd18);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1;
    drive(9, 9, 0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_Result", 64'(Result), 64'd0);
    chk("mid_Z", 64'(Z), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (40) begin @(negedge clk); if (done) n++; end
    chk("mid_no_done", 64'(n), 64'd0);
    run_op(100, 100, 0, 1'b0, 32'd10000, 1'b0, 1'b0);

    // Randomized ops with stray start pulses during RUN
    repeat (25) begin
      @(negedge clk);
      start = 1'b1;
      drive($urandom, $urandom, $urandom, 1'($urandom));
      @(negedge clk);
      start = 1'b0;
      wait_done(n, 1'b1);
      start = 1'b0;
      chk("rnd_latency", 64'(n), 64'(W + 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
